// File: rtl/icache_sa_pkg.sv
// Shared types, constants and address-field width helpers for the
// set-associative instruction cache.
package icache_sa_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIT_RESP,
    S_MISS_ADDR,
    S_MISS_DATA,
    S_FILL_RESP
  } state_e;

  localparam int LINE_BYTES = 16;
  localparam logic [2:0] RESP_OKAY = 3'b000;
  localparam logic [2:0] RESP_ERR  = 3'b010;

  function automatic int index_width(input int set_num);
    return $clog2(set_num);
  endfunction

  function automatic int tag_width(input int addr_len, input int set_num);
    return addr_len - $clog2(LINE_BYTES) - $clog2(set_num);
  endfunction

endpackage

// File: rtl/icache_sa_if.sv
// Fetch, flush and memory-read channels of the instruction cache.
// Every valid/ready pair transfers on a rising edge where both are high; the
// source holds valid and its payload stable until that edge.
interface icache_sa_if #(
  parameter int ADDR_LEN  = 32,
  parameter int BUS_WIDTH = 32
);
  logic                 ifu_arvalid;
  logic                 ifu_arready;
  logic [ADDR_LEN-3:0]  ifu_raddr;
  logic                 ifu_rvalid;
  logic                 ifu_rready;
  logic [31:0]          ifu_rdata;
  logic [2:0]           ifu_rresp;
  logic                 flush_valid;
  logic                 flush_ready;
  logic                 mem_arvalid;
  logic                 mem_arready;
  logic [ADDR_LEN-1:0]  mem_araddr;
  logic                 mem_rvalid;
  logic                 mem_rready;
  logic [2:0]           mem_rresp;
  logic [BUS_WIDTH-1:0] mem_rdata;

  modport slave (
    input  ifu_arvalid, ifu_raddr, ifu_rready, flush_valid,
           mem_arready, mem_rvalid, mem_rresp, mem_rdata,
    output ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp, flush_ready,
           mem_arvalid, mem_araddr, mem_rready
  );

  modport master (
    output ifu_arvalid, ifu_raddr, ifu_rready, flush_valid,
           mem_arready, mem_rvalid, mem_rresp, mem_rdata,
    input  ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp, flush_ready,
           mem_arvalid, mem_araddr, mem_rready
  );
endinterface

// File: rtl/icache_sa_way.sv
// One cache way: tag/valid flops read combinationally at idx, plus a
// 128-bit line store with a registered (one-cycle) read port.
module icache_sa_way #(
  parameter int SET_NUM = 64,
  parameter int IDX_W   = 6,
  parameter int TAG_W   = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [IDX_W-1:0]  idx,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [127:0]      wr_data,
  output logic              valid,
  output logic [TAG_W-1:0]  tag,
  output logic [127:0]      rdata
);

  logic [SET_NUM-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [SET_NUM];
  logic [127:0]       data_q [SET_NUM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Tags and data need no reset: they are only trusted behind a valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[idx]  <= wr_tag;
      data_q[idx] <= wr_data;
    end
    if (rd_en) begin
      rdata <= data_q[idx];
    end
  end

  assign valid = valid_q[idx];
  assign tag   = tag_q[idx];

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache: lookup FSM, miss line buffer,
// invalid-first / round-robin replacement and hit/access counters.
module icache_sa
  import icache_sa_pkg::*;
#(
  parameter int ADDR_LEN  = 32,
  parameter int BUS_WIDTH = 32,
  parameter int WAY_NUM   = 4,
  parameter int SET_NUM   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  icache_sa_if.slave  bus,
  output logic [31:0] hit_cnt,
  output logic [31:0] access_cnt,
  output state_e      dbg_state
);

  localparam int BEATS      = 128 / BUS_WIDTH;
  localparam int BEAT_SHIFT = $clog2(BUS_WIDTH / 8);
  localparam int IDX_W      = index_width(SET_NUM);
  localparam int TAG_W      = tag_width(ADDR_LEN, SET_NUM);
  localparam int WAY_W      = $clog2(WAY_NUM);
  localparam int WA         = ADDR_LEN - 2;

  state_e             state_q, state_d;
  logic [WA-1:0]      req_addr_q;
  logic [1:0]         beat_q;
  logic               err_q;
  logic [127:0]       line_q;
  logic [WAY_W-1:0]   hit_way_q;
  logic [WAY_W-1:0]   rr_q [SET_NUM];

  logic               accept, flush_go, hit_any, last_beat, fill_go;
  logic [IDX_W-1:0]   lk_idx, req_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic [WAY_W-1:0]   hit_idx, victim;
  logic [127:0]       fill_line, sel_line;
  logic [WAY_NUM-1:0] way_valid, way_hit, way_we;
  logic [TAG_W-1:0]   way_tag   [WAY_NUM];
  logic [127:0]       way_rdata [WAY_NUM];

  assign accept   = bus.ifu_arvalid & ~bus.flush_valid & (state_q == S_IDLE);
  assign flush_go = bus.flush_valid & (state_q == S_IDLE);
  assign req_idx  = req_addr_q[IDX_W+1:2];
  assign lk_tag   = bus.ifu_raddr[WA-1:IDX_W+2];
  // Outside IDLE the ways are indexed by the pending request so the victim
  // choice sees that set's valid bits.
  assign lk_idx   = (state_q == S_IDLE) ? bus.ifu_raddr[IDX_W+1:2] : req_idx;

  assign last_beat = (beat_q == 2'(BEATS - 1));
  assign fill_line = {bus.mem_rdata, line_q[127:BUS_WIDTH]};
  assign fill_go   = (state_q == S_MISS_DATA) & bus.mem_rvalid & last_beat &
                     ~err_q & (bus.mem_rresp == RESP_OKAY);

  for (genvar w = 0; w < WAY_NUM; w++) begin : g_way
    icache_sa_way #(
      .SET_NUM (SET_NUM),
      .IDX_W   (IDX_W),
      .TAG_W   (TAG_W)
    ) u_way (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush_go),
      .idx     (lk_idx),
      .rd_en   (accept),
      .wr_en   (way_we[w]),
      .wr_tag  (req_addr_q[WA-1:IDX_W+2]),
      .wr_data (fill_line),
      .valid   (way_valid[w]),
      .tag     (way_tag[w]),
      .rdata   (way_rdata[w])
    );
    assign way_hit[w] = way_valid[w] & (way_tag[w] == lk_tag);
    assign way_we[w]  = fill_go & (victim == WAY_W'(w));
  end

  // One-hot to index; the lowest matching way wins.
  always_comb begin
    hit_any = |way_hit;
    hit_idx = '0;
    for (int i = WAY_NUM - 1; i >= 0; i--) begin
      if (way_hit[i]) hit_idx = WAY_W'(i);
    end
  end

  always_comb begin
    logic found;
    found  = 1'b0;
    victim = rr_q[req_idx];
    for (int i = 0; i < WAY_NUM; i++) begin
      if (!way_valid[i] && !found) begin
        victim = WAY_W'(i);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    bus.ifu_arready  = 1'b0;
    bus.flush_ready  = 1'b0;
    bus.ifu_rvalid   = 1'b0;
    bus.ifu_rresp    = RESP_OKAY;
    bus.mem_arvalid  = 1'b0;
    bus.mem_rready   = 1'b1;
    sel_line         = way_rdata[hit_way_q];
    unique case (state_q)
      S_IDLE: begin
        bus.ifu_arready = ~bus.flush_valid;
        bus.flush_ready = 1'b1;
        if (accept) state_d = hit_any ? S_HIT_RESP : S_MISS_ADDR;
      end
      S_HIT_RESP: begin
        bus.ifu_rvalid = 1'b1;
        if (bus.ifu_rready) state_d = S_IDLE;
      end
      S_MISS_ADDR: begin
        bus.mem_arvalid = 1'b1;
        if (bus.mem_arready) state_d = S_MISS_DATA;
      end
      S_MISS_DATA: begin
        if (bus.mem_rvalid) state_d = last_beat ? S_FILL_RESP : S_MISS_ADDR;
      end
      S_FILL_RESP: begin
        bus.ifu_rvalid = 1'b1;
        bus.ifu_rresp  = err_q ? RESP_ERR : RESP_OKAY;
        sel_line       = line_q;
        if (bus.ifu_rready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ifu_rdata  = sel_line[{req_addr_q[1:0], 5'b0} +: 32];
  assign bus.mem_araddr = {req_addr_q[WA-1:2], 4'b0} | (ADDR_LEN'(beat_q) << BEAT_SHIFT);
  assign dbg_state      = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr_q <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
      line_q     <= '0;
      hit_way_q  <= '0;
      hit_cnt    <= '0;
      access_cnt <= '0;
    end else begin
      if (accept) begin
        req_addr_q <= bus.ifu_raddr;
        hit_way_q  <= hit_idx;
        beat_q     <= '0;
        err_q      <= 1'b0;
        access_cnt <= access_cnt + 32'd1;
        if (hit_any) hit_cnt <= hit_cnt + 32'd1;
      end
      if ((state_q == S_MISS_DATA) && bus.mem_rvalid) begin
        line_q <= fill_line;
        beat_q <= beat_q + 2'd1;
        if (bus.mem_rresp != RESP_OKAY) err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SET_NUM; s++) rr_q[s] <= '0;
    end else if (fill_go) begin
      rr_q[req_idx] <= rr_q[req_idx] + WAY_W'(1);
    end
  end

endmodule
